// File: rtl/blockade_inputs.sv
// blockade_inputs: debounces the raw joystick, coin and start inputs, stretches coin into a pulse,
// and latches the three active-low CPU input bytes on each vblank rising edge.
//
// Ports:
//   clk          core clock
//   reset        asynchronous, active-high reset
//   vblank       core vblank, active high, synchronous to clk
//   joy1, joy2   raw {up,down,left,right}, active high
//   coin, start  raw buttons, active high
//   dip          DIP switch bank, active high = ON
//   in0/in1/in2  CPU port bytes, active low, frame-coherent
//   coin_active  high while the stretched coin pulse is asserted
module blockade_inputs #(
  parameter logic [15:0] DEBOUNCE_CYCLES     = 16'd1000,
  parameter logic [19:0] COIN_PULSE_CYCLES   = 20'd200000,
  parameter logic [19:0] COIN_HOLDOFF_CYCLES = 20'd400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic [3:0] joy1,
  input  logic [3:0] joy2,
  input  logic       coin,
  input  logic       start,
  input  logic [7:0] dip,
  output logic [7:0] in0,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic       coin_active
);

  localparam int NRAW = 10;

  localparam logic [15:0] DB_LAST =
    DEBOUNCE_CYCLES - 16'd1;
  localparam logic [19:0] PULSE_LAST =
    COIN_PULSE_CYCLES - 20'd1;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLDOFF
  } coin_state_t;

  logic [NRAW-1:0] raw;
  logic [NRAW-1:0] db;

  logic [3:0] p1_db;
  logic [3:0] p2_db;
  logic       coin_db;
  logic       start_db;

  logic [3:0] p1;
  logic [3:0] p2;

  coin_state_t state;
  logic [19:0] coin_cnt;
  logic        coin_q;
  logic        coin_rise;

  logic vblank_q;
  logic vb_rise;

  assign raw = {joy1, joy2, coin, start};

  // Each bit needs DEBOUNCE_CYCLES consecutive
  // cycles at the new level; any return to the
  // settled level restarts the count.
  for (genvar i = 0; i < NRAW; i++) begin : g_db
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        db[i] <= 1'b0;
      end else if (raw[i] == db[i]) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt   <= '0;
        db[i] <= raw[i];
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign p1_db    = db[9:6];
  assign p2_db    = db[5:2];
  assign coin_db  = db[1];
  assign start_db = db[0];

  // Opposing directions cancel each other out.
  function automatic logic [3:0] resolve(
    input logic [3:0] j
  );
    resolve = {
      j[3] & ~j[2],
      j[2] & ~j[3],
      j[1] & ~j[0],
      j[0] & ~j[1]
    };
  endfunction

  assign p1 = resolve(p1_db);
  assign p2 = resolve(p2_db);

  // coin_q tracks the debounced level in every
  // state, so a coin held through HOLDOFF shows
  // no rising edge once the FSM is back in IDLE.
  assign coin_rise = coin_db & ~coin_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin_q <= 1'b0;
    end else begin
      coin_q <= coin_db;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      coin_cnt    <= '0;
      coin_active <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (coin_rise) begin
            state       <= PULSE;
            coin_cnt    <= '0;
            coin_active <= 1'b1;
          end
        end
        PULSE: begin
          if (coin_cnt == PULSE_LAST) begin
            state       <= HOLDOFF;
            coin_cnt    <= '0;
            coin_active <= 1'b0;
          end else begin
            coin_cnt <= coin_cnt + 20'd1;
          end
        end
        HOLDOFF: begin
          if (coin_cnt == COIN_HOLDOFF_CYCLES) begin
            if (!coin_db) begin
              state <= IDLE;
            end
          end else begin
            coin_cnt <= coin_cnt + 20'd1;
          end
        end
        default: begin
          state       <= IDLE;
          coin_cnt    <= '0;
          coin_active <= 1'b0;
        end
      endcase
    end
  end

  assign vb_rise = vblank & ~vblank_q;

  // The CPU sees one consistent snapshot per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q <= 1'b0;
      in0      <= 8'hFF;
      in1      <= 8'hFF;
      in2      <= 8'hFF;
    end else begin
      vblank_q <= vblank;
      if (vb_rise) begin
        in0 <= ~dip;
        in1 <= {~coin_active, 3'b111, ~p1};
        in2 <= {~start_db, 3'b111, ~p2};
      end
    end
  end

endmodule

// File: tb/tb_blockade_inputs.sv
// tb_blockade_inputs: directed vector bench for blockade_inputs.
// Small debounce/coin timings keep the run short.
module tb_blockade_inputs;

  logic       clk = 1'b0;
  logic       reset;
  logic       vblank;
  logic [3:0] joy1;
  logic [3:0] joy2;
  logic       coin;
  logic       start;
  logic [7:0] dip;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       coin_active;

  int passed = 0;
  int total  = 0;

  blockade_inputs #(
    .DEBOUNCE_CYCLES    (16'd4),
    .COIN_PULSE_CYCLES  (20'd10),
    .COIN_HOLDOFF_CYCLES(20'd5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vblank     (vblank),
    .joy1       (joy1),
    .joy2       (joy2),
    .coin       (coin),
    .start      (start),
    .dip        (dip),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .coin_active(coin_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] j1;
    logic [3:0] j2;
    logic       st;
    logic [7:0] dp;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vblank = 1'b1;
    cyc(1);
    vblank = 1'b0;
    cyc(1);
  endtask

  task automatic count_active(
    input  int n,
    output int highs,
    output int rises
  );
    logic prev;
    prev  = coin_active;
    highs = 0;
    rises = 0;
    for (int k = 0; k < n; k++) begin
      cyc(1);
      if (coin_active) highs++;
      if (coin_active && !prev) rises++;
      prev = coin_active;
    end
  endtask

  task automatic wait_active(
    input string nm,
    input logic  tgt,
    input int    max
  );
    int k;
    k = 0;
    while (coin_active !== tgt && k < max) begin
      cyc(1);
      k++;
    end
    chk(nm, {31'd0, coin_active}, {31'd0, tgt});
  endtask

  initial begin
    int h;
    int r;

    vecs[0] = '{4'b1000, 4'b0000, 1'b0, 8'h00,
                8'hFF, 8'hF7, 8'hFF};
    vecs[1] = '{4'b1100, 4'b0011, 1'b0, 8'h00,
                8'hFF, 8'hFF, 8'hFF};
    vecs[2] = '{4'b1010, 4'b0000, 1'b0, 8'h00,
                8'hFF, 8'hF5, 8'hFF};
    vecs[3] = '{4'b0101, 4'b0110, 1'b0, 8'h00,
                8'hFF, 8'hFA, 8'hF9};
    vecs[4] = '{4'b1111, 4'b1001, 1'b1, 8'h00,
                8'hFF, 8'hFF, 8'h76};
    vecs[5] = '{4'b0000, 4'b0000, 1'b0, 8'h5A,
                8'hA5, 8'hFF, 8'hFF};
    vecs[6] = '{4'b0000, 4'b0000, 1'b0, 8'hFF,
                8'h00, 8'hFF, 8'hFF};

    reset  = 1'b1;
    vblank = 1'b0;
    joy1   = '0;
    joy2   = '0;
    coin   = 1'b0;
    start  = 1'b0;
    dip    = 8'h00;
    cyc(3);
    chk("rst_in0", in0, 8'hFF);
    chk("rst_in1", in1, 8'hFF);
    chk("rst_in2", in2, 8'hFF);
    chk("rst_coin", coin_active, 0);
    reset = 1'b0;
    cyc(2);

    // Three-cycle glitch is discarded.
    joy1 = 4'b1000;
    cyc(3);
    joy1 = 4'b0000;
    cyc(4);
    frame();
    chk("glitch_in1", in1, 8'hFF);

    // Four-cycle hold is accepted.
    joy1 = 4'b1000;
    cyc(4);
    frame();
    chk("hold_in1", in1, 8'hF7);

    for (int i = 0; i < 7; i++) begin
      joy1  = vecs[i].j1;
      joy2  = vecs[i].j2;
      start = vecs[i].st;
      dip   = vecs[i].dp;
      cyc(6);
      frame();
      chk($sformatf("v%0d_in0", i), in0, vecs[i].e0);
      chk($sformatf("v%0d_in1", i), in1, vecs[i].e1);
      chk($sformatf("v%0d_in2", i), in2, vecs[i].e2);
    end

    // dip change mid-frame waits for next edge.
    dip = 8'h5A;
    frame();
    chk("dip_a5", in0, 8'hA5);
    dip = 8'h00;
    cyc(5);
    chk("dip_hold", in0, 8'hA5);
    frame();
    chk("dip_next", in0, 8'hFF);

    // Held coin: exactly one 10-cycle pulse.
    coin = 1'b1;
    count_active(100, h, r);
    chk("coin1_len", h, 10);
    chk("coin1_rises", r, 1);
    coin = 1'b0;
    cyc(20);
    coin = 1'b1;
    count_active(40, h, r);
    chk("coin2_len", h, 10);
    chk("coin2_rises", r, 1);
    coin = 1'b0;
    cyc(30);

    // Pulse captured across a vblank edge.
    coin = 1'b1;
    wait_active("wait_hi_a", 1'b1, 20);
    frame();
    chk("vb_coin_on", in1, 8'h7F);
    wait_active("wait_lo_a", 1'b0, 20);
    frame();
    chk("vb_coin_off", in1, 8'hFF);
    coin = 1'b0;
    cyc(30);

    // Async reset mid-pulse.
    dip = 8'h3C;
    coin = 1'b1;
    wait_active("wait_hi_b", 1'b1, 20);
    frame();
    chk("pre_rst_in1", in1, 8'h7F);
    chk("pre_rst_in0", in0, 8'hC3);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_in0", in0, 8'hFF);
    chk("arst_in1", in1, 8'hFF);
    chk("arst_in2", in2, 8'hFF);
    chk("arst_coin", coin_active, 0);
    cyc(2);
    reset = 1'b0;

    // Still-held coin yields one fresh pulse.
    count_active(40, h, r);
    chk("post_rst_len", h, 10);
    chk("post_rst_rises", r, 1);
    chk("post_rst_in1", in1, 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
